// File: rtl/seg7_serial_tx.sv
// Serial transmitter for the 8-digit seven-segment display: decodes, gates and
// shifts a 64-bit frame into the board's external segment shift-register chain.
module seg7_serial_tx #(
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_latch,
  output logic        seg_clrn
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

  state_t                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [5:0]              bit_q;
  logic                    busy_q, done_q, seg_clk_q, sout_q, latch_q, clrn_q;
  logic [BLINK_BITS-1:0]   blink_cnt_q;
  logic [31:0]             num_q;
  logic [7:0]              point_q, blink_q;
  logic                    phase_q;
  logic [62:0]             frame_q;
  logic [63:0]             frame_d;
  logic                    capture, shift_step;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Byte i = {dp, g..a} of digit i; digit 7 lands in the top byte so it leaves first.
  always_comb begin
    frame_d = '0;
    for (int i = 0; i < 8; i++) begin
      frame_d[8*i +: 8] = {point_q[i], hex_to_seg(num_q[4*i +: 4])};
      if (blink_q[i] && phase_q) frame_d[8*i +: 8] = 8'h00;
    end
    if (ACTIVE_LOW) frame_d = ~frame_d;
  end

  assign capture    = (state_q == IDLE) && start;
  assign shift_step = (state_q == SHIFT) && (div_q == DIV_LAST) && seg_clk_q && (bit_q != 6'd63);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_q + 1'b1;
  end

  // Datapath holding registers carry no reset; the frame's MSB lives in sout_q.
  always_ff @(posedge clk) begin
    if (capture) begin
      num_q   <= Disp_num;
      point_q <= point_in;
      blink_q <= blink_in;
      phase_q <= blink_cnt_q[BLINK_BITS-1];
    end
    if (state_q == LOAD)  frame_q <= frame_d[62:0];
    else if (shift_step)  frame_q <= {frame_q[61:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_clk_q <= 1'b0;
      sout_q    <= 1'b0;
      latch_q   <= 1'b0;
      clrn_q    <= 1'b0;
    end else begin
      clrn_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          sout_q    <= frame_d[63];
          seg_clk_q <= 1'b0;
          div_q     <= '0;
          bit_q     <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              // Data only moves on the falling edge so the receiver sees it stable.
              seg_clk_q <= 1'b0;
              if (bit_q == 6'd63) begin
                latch_q <= 1'b1;
                state_q <= LATCH;
              end else begin
                bit_q  <= bit_q + 6'd1;
                sout_q <= frame_q[62];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        LATCH: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign seg_clk   = seg_clk_q;
  assign seg_sout  = sout_q;
  assign seg_latch = latch_q;
  assign seg_clrn  = clrn_q;
endmodule

// File: tb/tb_seg7_serial_tx.sv
// Scoreboard bench for seg7_serial_tx: directed frames queued at start, compared
// byte-by-byte when the monitor sees each latch pulse.
module tb_seg7_serial_tx;
  localparam int CLK_DIV    = 2;
  localparam int BLINK_BITS = 4;
  localparam int FRAME_CYC  = 1 + 128*CLK_DIV + CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] disp = '0;
  logic [7:0]  pt = '0;
  logic [7:0]  bl = '0;
  logic        busy, done, seg_clk, seg_sout, seg_latch, seg_clrn;

  seg7_serial_tx #(.CLK_DIV(CLK_DIV), .BLINK_BITS(BLINK_BITS), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .Disp_num(disp), .point_in(pt), .blink_in(bl),
    .busy(busy), .done(done), .seg_clk(seg_clk), .seg_sout(seg_sout),
    .seg_latch(seg_latch), .seg_clrn(seg_clrn));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, n_done = 0, n_latch = 0;
  logic [63:0] exp_q[$];
  logic [BLINK_BITS-1:0] bc_model;

  always @(posedge clk or posedge rst) begin
    if (rst) bc_model <= '0;
    else     bc_model <= bc_model + 1'b1;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor
  logic        prev_sclk = 1'b0, prev_sout = 1'b0, prev_latch = 1'b0;
  int          nbits = 0, lat_w = 0;
  logic [63:0] sh = '0;
  logic [63:0] mon_want;
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      lat_w = 0;
    end else begin
      if (seg_clk && prev_sclk && (seg_sout !== prev_sout))
        check("sout_stable_while_high", 64'(seg_sout), 64'(prev_sout));
      if (seg_clk && !prev_sclk) begin
        sh = {sh[62:0], seg_sout};
        nbits++;
      end
      if (seg_latch) lat_w++;
      if (!seg_latch && prev_latch) begin
        n_latch++;
        check("latch_width", 64'(lat_w), 64'(CLK_DIV));
        check("bit_count", 64'(nbits), 64'd64);
        check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_want = exp_q.pop_front();
          for (int b = 7; b >= 0; b--)
            check($sformatf("digit%0d_byte", b), 64'(sh[8*b +: 8]), 64'(mon_want[8*b +: 8]));
        end
        nbits = 0;
        lat_w = 0;
      end
      if (done) n_done++;
    end
    prev_sclk  = rst ? 1'b0 : seg_clk;
    prev_sout  = rst ? 1'b0 : seg_sout;
    prev_latch = rst ? 1'b0 : seg_latch;
  end

  task automatic send(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                      input int want_phase, input bit poke, input logic [63:0] want);
    int cyc, guard, d0;
    guard = 0;
    @(negedge clk);
    while (want_phase >= 0 && bc_model[BLINK_BITS-1] != want_phase[0] && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    disp = d; pt = p; bl = b; start = 1'b1;
    exp_q.push_back(want);
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 2*FRAME_CYC) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) begin
        if (cyc == 10) begin start = 1'b1; disp = ~d; end
        else start = 1'b0;
      end
    end
    // done is registered high after edge cyc and is taken by the following edge
    check("done_latency", 64'(cyc + 1), 64'(FRAME_CYC));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("done_count", 64'(n_done - d0), 64'd1);
    check("no_second_frame", 64'(busy), 64'd0);
  endtask

  initial begin
    int guard, nl;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_seg_clk", 64'(seg_clk), 64'd0);
    check("rst_seg_sout", 64'(seg_sout), 64'd0);
    check("rst_seg_latch", 64'(seg_latch), 64'd0);
    check("rst_seg_clrn", 64'(seg_clrn), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("clrn_after_release", 64'(seg_clrn), 64'd1);
    check("busy_after_release", 64'(busy), 64'd0);
    #3 rst = 1'b1;
    #1 check("async_rst_clrn", 64'(seg_clrn), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("clrn_after_release2", 64'(seg_clrn), 64'd1);

    send(32'h01234567, 8'h00, 8'h00, -1, 1'b0, 64'hC0F9A4B0999282F8);
    send(32'h89ABCDEF, 8'h81, 8'h00, -1, 1'b0, 64'h00908883C6A1860E);
    send(32'h88888888, 8'h00, 8'h0F,  1, 1'b0, 64'h80808080FFFFFFFF);
    send(32'h88888888, 8'h00, 8'h0F,  0, 1'b0, 64'h8080808080808080);
    send(32'h01234567, 8'h00, 8'h00, -1, 1'b1, 64'hC0F9A4B0999282F8);

    // Abandon a frame at bit 30
    @(negedge clk);
    disp = 32'h01234567; pt = '0; bl = '0; start = 1'b1;
    exp_q.push_back(64'hC0F9A4B0999282F8);
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (nbits < 30 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    check("reached_bit30", 64'(nbits), 64'd30);
    nl = n_latch;
    #2 rst = 1'b1;
    #1;
    check("abort_seg_clk", 64'(seg_clk), 64'd0);
    check("abort_seg_sout", 64'(seg_sout), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_seg_latch", 64'(seg_latch), 64'd0);
    check("abort_seg_clrn", 64'(seg_clrn), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("abort_clrn_release", 64'(seg_clrn), 64'd1);
    check("abort_busy_release", 64'(busy), 64'd0);
    repeat (300) @(posedge clk);
    #1;
    check("abort_no_latch", 64'(n_latch), 64'(nl));
    send(32'hFEDCBA98, 8'h00, 8'h00, -1, 1'b0, 64'h8E86A1C683889080);

    check("frames_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
